// File: rtl/ghash_pkg.sv
// Shared definitions for the GHASH sequencing controller.
//   - MUX_* : datapath input-select encodings (AAD, ciphertext, length block)
//   - ghash_state_e : controller state enumeration
//   - BLK_CNT_W : width of the per-message 128-bit block counters
//   - blk_count() : bit length to number of 128-bit blocks, rounded up
package ghash_pkg;

  localparam int unsigned BLK_CNT_W = 57;

  localparam logic [1:0] MUX_AAD = 2'b00;
  localparam logic [1:0] MUX_CT  = 2'b01;
  localparam logic [1:0] MUX_LEN = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    INIT_CLR,
    INIT_ZS,
    AAD_ABS,
    AAD_MUL,
    CT_ABS,
    CT_MUL,
    LEN_ABS,
    LEN_MUL,
    DONE
  } ghash_state_e;

  // Ceiling of len_bits / 128. Computed as whole blocks plus one for any
  // partial block, so no wider intermediate sum is needed.
  function automatic logic [BLK_CNT_W-1:0] blk_count(input logic [63:0] len_bits);
    logic [BLK_CNT_W-1:0] whole;
    whole = len_bits[63:7];
    return whole + BLK_CNT_W'(|len_bits[6:0]);
  endfunction

endpackage

// File: rtl/ghash_ctrl_if.sv
// Block-stream and tag handshake bundle between the GHASH controller and its
// neighbours.
//   in_valid  : upstream has a block on the datapath inputs
//   in_ready  : controller absorbs the block this cycle (with in_valid)
//   tag_valid : datapath S register holds the final GHASH value
//   tag_ready : downstream consumed the tag
// Modports: master = environment (upstream source / tag sink), slave = controller.
interface ghash_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic tag_valid;
  logic tag_ready;

  modport master (
    output in_valid,
    output tag_ready,
    input  in_ready,
    input  tag_valid
  );

  modport slave (
    input  in_valid,
    input  tag_ready,
    output in_ready,
    output tag_valid
  );
endinterface

// File: rtl/ghash_blk_cnt.sv
// Loadable down-counter of 128-bit blocks.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : block count to load
//   dec_i        : decrement by one (saturates at zero)
//   zero_o       : count is zero
//   last_o       : count is one, i.e. zero after the next decrement
module ghash_blk_cnt
  import ghash_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [BLK_CNT_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 zero_o,
  output logic                 last_o
);

  logic [BLK_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - BLK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == BLK_CNT_W'(1));

endmodule

// File: rtl/ghash_ctrl.sv
// Sequencing controller for the GHASH datapath. Per message it clears the
// accumulator, zeroes S, absorbs nA AAD blocks and nC ciphertext blocks, then
// the GCM length block, and finally holds tag_valid until tag_ready.
//   clk, rst        : clock, synchronous active-high reset
//   h_load_i        : load hash key H (IDLE only)
//   start_i         : begin a message (IDLE only)
//   aad_len_bits_i  : AAD length in bits, sampled on accepted start
//   ct_len_bits_i   : ciphertext length in bits, sampled on accepted start
//   bus             : block and tag handshakes (slave side)
//   h_reg_en_o, mux_sel_o, ac_reg_en_o, ac_clr_o, s_reg_en_o : datapath controls
//   length_data_o   : registered {aad_len_bits, ct_len_bits} length block
//   busy_o          : high in every state except IDLE
module ghash_ctrl
  import ghash_pkg::*;
#(
  // Only 128 is meaningful; the length block is two 64-bit fields.
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_load_i,
  input  logic             start_i,
  input  logic [63:0]      aad_len_bits_i,
  input  logic [63:0]      ct_len_bits_i,
  ghash_ctrl_if.slave      bus,
  output logic             h_reg_en_o,
  output logic [1:0]       mux_sel_o,
  output logic             ac_reg_en_o,
  output logic             ac_clr_o,
  output logic             s_reg_en_o,
  output logic [WIDTH-1:0] length_data_o,
  output logic             busy_o
);

  ghash_state_e     state_q, state_d;
  logic [WIDTH-1:0] length_q;

  logic start_acc;
  logic aad_zero, aad_last;
  logic ct_zero, ct_last;
  logic in_ready, tag_valid;

  assign start_acc = (state_q == IDLE) && start_i;

  ghash_blk_cnt u_aad_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_acc),
    .load_val_i (blk_count(aad_len_bits_i)),
    .dec_i      (state_q == AAD_MUL),
    .zero_o     (aad_zero),
    .last_o     (aad_last)
  );

  ghash_blk_cnt u_ct_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_acc),
    .load_val_i (blk_count(ct_len_bits_i)),
    .dec_i      (state_q == CT_MUL),
    .zero_o     (ct_zero),
    .last_o     (ct_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      length_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        length_q <= WIDTH'({aad_len_bits_i, ct_len_bits_i});
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    h_reg_en_o  = 1'b0;
    mux_sel_o   = MUX_AAD;
    ac_reg_en_o = 1'b0;
    ac_clr_o    = 1'b0;
    s_reg_en_o  = 1'b0;
    in_ready    = 1'b0;
    tag_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        h_reg_en_o = h_load_i;
        if (start_i) begin
          state_d = INIT_CLR;
        end
      end

      INIT_CLR: begin
        ac_clr_o = 1'b1;
        state_d  = INIT_ZS;
      end

      // S <= H * 0 = 0; counts were loaded on start so the flags are valid here.
      INIT_ZS: begin
        s_reg_en_o = 1'b1;
        if (!aad_zero) begin
          state_d = AAD_ABS;
        end else if (!ct_zero) begin
          state_d = CT_ABS;
        end else begin
          state_d = LEN_ABS;
        end
      end

      AAD_ABS: begin
        mux_sel_o   = MUX_AAD;
        in_ready    = 1'b1;
        ac_reg_en_o = bus.in_valid;
        if (bus.in_valid) begin
          state_d = AAD_MUL;
        end
      end

      // The counter decrements this cycle, so "last" means none remain after it.
      AAD_MUL: begin
        mux_sel_o  = MUX_AAD;
        s_reg_en_o = 1'b1;
        if (!aad_last) begin
          state_d = AAD_ABS;
        end else if (!ct_zero) begin
          state_d = CT_ABS;
        end else begin
          state_d = LEN_ABS;
        end
      end

      CT_ABS: begin
        mux_sel_o   = MUX_CT;
        in_ready    = 1'b1;
        ac_reg_en_o = bus.in_valid;
        if (bus.in_valid) begin
          state_d = CT_MUL;
        end
      end

      CT_MUL: begin
        mux_sel_o  = MUX_CT;
        s_reg_en_o = 1'b1;
        state_d    = ct_last ? LEN_ABS : CT_ABS;
      end

      LEN_ABS: begin
        mux_sel_o   = MUX_LEN;
        ac_reg_en_o = 1'b1;
        state_d     = LEN_MUL;
      end

      LEN_MUL: begin
        mux_sel_o  = MUX_LEN;
        s_reg_en_o = 1'b1;
        state_d    = DONE;
      end

      DONE: begin
        tag_valid = 1'b1;
        if (bus.tag_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.tag_valid = tag_valid;
  assign length_data_o = length_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ghash_ctrl.sv
// Self-checking bench for ghash_ctrl. For each message the bench derives from
// the lengths the ordered list of datapath enable events, the tag latency and
// the length block, drives the block stream with planned stalls and random
// noise outside the absorb window, and compares against what it observes.
module tb_ghash_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         h_load;
  logic         start;
  logic [63:0]  aad_len_bits;
  logic [63:0]  ct_len_bits;
  logic         h_reg_en;
  logic [1:0]   mux_sel;
  logic         ac_reg_en;
  logic         ac_clr;
  logic         s_reg_en;
  logic [127:0] length_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ghash_ctrl_if bus ();

  ghash_ctrl #(
    .WIDTH (128)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .h_load_i       (h_load),
    .start_i        (start),
    .aad_len_bits_i (aad_len_bits),
    .ct_len_bits_i  (ct_len_bits),
    .bus            (bus),
    .h_reg_en_o     (h_reg_en),
    .mux_sel_o      (mux_sel),
    .ac_reg_en_o    (ac_reg_en),
    .ac_clr_o       (ac_clr),
    .s_reg_en_o     (s_reg_en),
    .length_data_o  (length_data),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event codes: 4 = accumulator clear, 8|mux = accumulator load, C = S load.
  task automatic run_msg(input logic [63:0] aad_l, input logic [63:0] ct_l, input int stall,
                         input int tag_delay, input logic hl, input int coll_req);
    int         na, nc, nblk, exp_tag, sum_st, k, blk, stall_left, done_seen, tag_cycle;
    int         coll_at, multi_en, h_busy, done_en, n_en, nmin;
    bit         finished, hs;
    int         stalls[$];
    logic [3:0] exp_ev[$];
    logic [3:0] obs_ev[$];

    na   = int'((aad_l + 64'd127) / 64'd128);
    nc   = int'((ct_l + 64'd127) / 64'd128);
    nblk = na + nc;
    sum_st = 0;
    for (int i = 0; i < nblk; i++) begin
      stalls.push_back((stall >= 0) ? stall : int'($urandom_range(0, 3)));
      sum_st += stalls[i];
    end
    exp_tag = 2 * nblk + 5 + sum_st;
    coll_at = (coll_req == -2) ? int'($urandom_range(2, 2 * nblk + 4)) : coll_req;

    exp_ev.push_back(4'h4);
    exp_ev.push_back(4'hC);
    for (int i = 0; i < na; i++) begin
      exp_ev.push_back(4'h8);
      exp_ev.push_back(4'hC);
    end
    for (int i = 0; i < nc; i++) begin
      exp_ev.push_back(4'h9);
      exp_ev.push_back(4'hC);
    end
    exp_ev.push_back(4'hA);
    exp_ev.push_back(4'hC);

    k = 0; blk = 0; done_seen = 0; tag_cycle = -1; finished = 0;
    multi_en = 0; h_busy = 0; done_en = 0;
    stall_left = (nblk > 0) ? stalls[0] : 0;

    while (!finished && k < 1000) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b1; h_load = hl; aad_len_bits = aad_l; ct_len_bits = ct_l;
      end else begin
        start  = (k == coll_at);
        h_load = (k == coll_at);
        aad_len_bits = {$urandom, $urandom};
        ct_len_bits  = {$urandom, $urandom};
      end
      hs = 0;
      if (bus.in_ready) begin
        if (stall_left > 0) begin
          bus.in_valid = 1'b0;
          stall_left--;
        end else begin
          bus.in_valid = 1'b1;
          hs = 1;
        end
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      if (bus.tag_valid) bus.tag_ready = (done_seen >= tag_delay);
      else               bus.tag_ready = 1'($urandom_range(0, 1));
      #1;
      if (k == 0) begin
        check_eq("idle_h_reg_en", h_reg_en, hl);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_in_ready", bus.in_ready, 1'b0);
      end
      if (k == 1) check_eq("busy_after_start", busy, 1'b1);
      n_en = int'(ac_clr) + int'(ac_reg_en) + int'(s_reg_en);
      if (n_en > 1) multi_en++;
      if (ac_clr)         obs_ev.push_back(4'h4);
      else if (ac_reg_en) obs_ev.push_back({2'b10, mux_sel});
      else if (s_reg_en)  obs_ev.push_back(4'hC);
      if (busy && h_reg_en) h_busy++;
      if (bus.tag_valid) begin
        if (tag_cycle < 0) begin
          tag_cycle = k;
          check_eq("tag_cycle", k, exp_tag);
          check_eq("length_data", length_data, {aad_l, ct_l});
        end
        if (n_en != 0) done_en++;
        done_seen++;
        if (bus.tag_ready) finished = 1;
      end
      if (hs) begin
        blk++;
        stall_left = (blk < nblk) ? stalls[blk] : 0;
      end
      k++;
    end
    check_eq("tag_handshake_seen", finished, 1'b1);

    @(negedge clk);
    start = 1'b0; h_load = 1'b0; bus.tag_ready = 1'b0; bus.in_valid = 1'b0;
    #1;
    check_eq("idle_after_tag", {busy, bus.tag_valid}, 2'b00);
    check_eq("handshakes", blk, nblk);
    check_eq("event_count", obs_ev.size(), exp_ev.size());
    nmin = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < nmin; i++) begin
      check_eq($sformatf("event_%0d", i), obs_ev[i], exp_ev[i]);
    end
    check_eq("multi_enable_cycles", multi_en, 0);
    check_eq("h_reg_en_while_busy", h_busy, 0);
    check_eq("enables_in_done", done_en, 0);
    check_eq("tag_hold_cycles", done_seen, tag_delay + 1);
  endtask

  // Reset in the first AAD_MUL of a 256/128-bit message.
  task automatic run_reset_mid();
    @(negedge clk);
    start = 1'b1; h_load = 1'b1; aad_len_bits = 64'd256; ct_len_bits = 64'd128;
    bus.in_valid = 1'b1; bus.tag_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0; h_load = 1'b0;
    end
    #1;
    check_eq("pre_rst_aad_mul", {s_reg_en, mux_sel, busy}, 4'b1001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_outputs",
             {h_reg_en, mux_sel, ac_reg_en, ac_clr, s_reg_en, busy, bus.in_ready, bus.tag_valid},
             10'd0);
    check_eq("post_rst_length", length_data, 128'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_load = 1'b0; start = 1'b0;
    aad_len_bits = '0; ct_len_bits = '0;
    bus.in_valid = 1'b0; bus.tag_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs",
             {h_reg_en, mux_sel, ac_reg_en, ac_clr, s_reg_en, busy, bus.in_ready, bus.tag_valid},
             10'd0);
    check_eq("reset_length", length_data, 128'd0);
    rst = 1'b0;

    run_msg(64'd0,   64'd0,   0, 0, 1'b1, -1);
    run_msg(64'd256, 64'd128, 0, 0, 1'b0, -1);
    run_msg(64'd8,   64'd136, 0, 0, 1'b1, -1);
    run_msg(64'd256, 64'd128, 3, 0, 1'b0, -1);
    run_msg(64'd256, 64'd128, 0, 4, 1'b0, 6);
    run_reset_mid();
    run_msg(64'd256, 64'd128, 0, 0, 1'b0, -1);

    for (int m = 0; m < 12; m++) begin
      run_msg(64'($urandom_range(0, 700)), 64'($urandom_range(0, 700)), -1,
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
